// File: rtl/lat_mem_model.sv
// Fixed-latency behavioural memory with tagged reads and masked writes.
// Reads drain through a delay line; writes take a separate data beat.
module lat_mem_model #(
  parameter int unsigned DATA_BITS  = 128,
  parameter int unsigned ADDR_BITS  = 28,
  parameter int unsigned TAG_BITS   = 5,
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned REQ_GAP    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [TAG_BITS-1:0]    mem_resp_tag,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count
);

  localparam int unsigned MW = DATA_BITS / 8;
  localparam int unsigned ENTRIES = 1 << DEPTH_LOG2;
  localparam int unsigned GW =
    (REQ_GAP > 0) ? $clog2(REQ_GAP + 1) : 1;

  typedef enum logic {IDLE, WDATA} state_t;

  state_t state, state_nx;

  logic [DATA_BITS-1:0]  ram [ENTRIES];
  logic [GW-1:0]         gap;
  logic [DEPTH_LOG2-1:0] raddr;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [LATENCY-1:0]    pv;
  logic [TAG_BITS-1:0]   pt [LATENCY];
  logic [DATA_BITS-1:0]  pd [LATENCY];
  logic [31:0]           rdc;
  logic [31:0]           wrc;
  logic                  req_ok;
  logic                  data_ok;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_done;
  logic                  unused_addr;

  // Upper address bits alias onto the RAM by design.
  assign unused_addr = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];
  assign raddr = mem_req_addr[DEPTH_LOG2-1:0];

  // Next-state and handshake readiness.
  always_comb begin
    state_nx = state;
    req_ok   = 1'b0;
    data_ok  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ok = (gap == '0);
        if (mem_req_valid && req_ok && mem_req_rw)
          state_nx = WDATA;
      end
      WDATA: begin
        data_ok = 1'b1;
        if (mem_req_data_valid)
          state_nx = IDLE;
      end
    endcase
  end

  assign mem_req_ready      = reset | req_ok;
  assign mem_req_data_ready = ~reset & data_ok;

  assign rd_acc  = ~reset & mem_req_valid & req_ok & ~mem_req_rw;
  assign wr_acc  = ~reset & mem_req_valid & req_ok & mem_req_rw;
  assign wr_done = ~reset & data_ok & mem_req_data_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Gap throttle: reload on read accept or write completion.
  always_ff @(posedge clk) begin
    if (reset)
      gap <= '0;
    else if (rd_acc || wr_done)
      gap <= GW'(REQ_GAP);
    else if (state == IDLE && gap != '0)
      gap <= gap - 1'b1;
  end

  // Latch the write address until its data beat arrives.
  always_ff @(posedge clk) begin
    if (wr_acc) waddr <= raddr;
  end

  // Byte-masked RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_done) begin
      for (int i = 0; i < MW; i++) begin
        if (mem_req_data_mask[i])
          ram[waddr][i*8 +: 8] <= mem_req_data_bits[i*8 +: 8];
      end
    end
  end

  // Delay-line valids; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      pv <= '0;
    end else begin
      pv[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++)
        pv[i] <= pv[i-1];
    end
  end

  // Delay-line payload, sampled from RAM in the accept cycle.
  always_ff @(posedge clk) begin
    pt[0] <= mem_req_tag;
    pd[0] <= ram[raddr];
    for (int i = 1; i < LATENCY; i++) begin
      pt[i] <= pt[i-1];
      pd[i] <= pd[i-1];
    end
  end

  // Wrapping transaction counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdc <= '0;
      wrc <= '0;
    end else begin
      if (rd_acc)  rdc <= rdc + 32'd1;
      if (wr_done) wrc <= wrc + 32'd1;
    end
  end

  assign mem_resp_valid = ~reset & pv[LATENCY-1];
  assign mem_resp_tag   = mem_resp_valid ? pt[LATENCY-1] : '0;
  assign mem_resp_data  = mem_resp_valid ? pd[LATENCY-1] : '0;
  assign rd_count       = reset ? 32'd0 : rdc;
  assign wr_count       = reset ? 32'd0 : wrc;

endmodule

// File: tb/tb_lat_mem_model.sv
// Bench for lat_mem_model: directed and random traffic
// against a queue-based reference of the memory.
module tb_lat_mem_model;

  localparam int L  = 4;
  localparam int DL = 14;
  localparam int D  = 1 << DL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         valid, ready, rw;
  logic [27:0]  addr;
  logic [4:0]   tag;
  logic         dvalid, dready;
  logic [127:0] dbits;
  logic [15:0]  dmask;
  logic         rvalid;
  logic [4:0]   rtag;
  logic [127:0] rdata;
  logic [31:0]  rdcnt, wrcnt;

  logic         g_valid, g_ready, g_dready, g_rvalid;
  logic [4:0]   g_rtag;
  logic [127:0] g_rdata;
  logic [31:0]  g_rdcnt, g_wrcnt;

  lat_mem_model #(.LATENCY(L), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(valid), .mem_req_ready(ready),
    .mem_req_rw(rw), .mem_req_addr(addr),
    .mem_req_tag(tag),
    .mem_req_data_valid(dvalid),
    .mem_req_data_ready(dready),
    .mem_req_data_bits(dbits),
    .mem_req_data_mask(dmask),
    .mem_resp_valid(rvalid), .mem_resp_tag(rtag),
    .mem_resp_data(rdata),
    .rd_count(rdcnt), .wr_count(wrcnt)
  );

  lat_mem_model #(.LATENCY(L), .DEPTH_LOG2(DL),
                  .REQ_GAP(2)) dut_g (
    .clk(clk), .reset(reset),
    .mem_req_valid(g_valid), .mem_req_ready(g_ready),
    .mem_req_rw(1'b0), .mem_req_addr(28'd0),
    .mem_req_tag(5'd0),
    .mem_req_data_valid(1'b0),
    .mem_req_data_ready(g_dready),
    .mem_req_data_bits(128'd0),
    .mem_req_data_mask(16'd0),
    .mem_resp_valid(g_rvalid), .mem_resp_tag(g_rtag),
    .mem_resp_data(g_rdata),
    .rd_count(g_rdcnt), .wr_count(g_wrcnt)
  );

  typedef struct {
    int           due;
    logic [4:0]   tag;
    logic [127:0] data;
  } rsp_t;

  rsp_t         q[$];
  logic [127:0] mref [int];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           wpend = 0;
  int           waddr = 0;
  int unsigned  rdc = 0;
  int unsigned  wrc = 0;
  int           g_last = -100;

  task automatic chk(string name, logic [127:0] obs,
                     logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             name, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: check outputs at negedge, advance model, cross edge.
  task automatic step();
    logic         er, ed, ge, xv;
    logic [4:0]   xt;
    logic [127:0] xd;
    int           a;
    @(negedge clk);
    while (q.size() > 0 && q[0].due < cyc)
      void'(q.pop_front());
    er = reset ? 1'b1 : !wpend;
    ed = !reset && wpend;
    ge = reset ? 1'b1 : (cyc - g_last >= 3);
    xv = 1'b0;
    xt = '0;
    xd = '0;
    if (!reset && q.size() > 0 && q[0].due == cyc) begin
      xv = 1'b1;
      xt = q[0].tag;
      xd = q[0].data;
    end
    chk("req_ready", ready, er);
    chk("data_ready", dready, ed);
    chk("resp_valid", rvalid, xv);
    chk("resp_tag", rtag, xt);
    chk("resp_data", rdata, xd);
    chk("rd_count", rdcnt, reset ? 0 : rdc);
    chk("wr_count", wrcnt, reset ? 0 : wrc);
    chk("gap_ready", g_ready, ge);
    if (reset) begin
      q.delete();
      wpend = 0;
      rdc = 0;
      wrc = 0;
      g_last = -100;
    end else begin
      if (xv) void'(q.pop_front());
      if (wpend && dvalid) begin
        for (int i = 0; i < 16; i++)
          if (dmask[i])
            mref[waddr][i*8 +: 8] = dbits[i*8 +: 8];
        wrc++;
        wpend = 0;
      end
      if (valid && er) begin
        a = int'(addr) % D;
        if (rw) begin
          wpend = 1;
          waddr = a;
        end else begin
          q.push_back('{cyc + L, tag, mref[a]});
          rdc++;
        end
      end
      if (g_valid && ge) g_last = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    valid = 0;
    dvalid = 0;
    repeat (n) step();
  endtask

  task automatic do_read(int a, int t);
    valid = 1;
    rw = 0;
    addr = 28'(a);
    tag = 5'(t);
    step();
    valid = 0;
  endtask

  task automatic do_write(int a, logic [127:0] d,
                          logic [15:0] m, int hold);
    valid = 1;
    rw = 1;
    addr = 28'(a);
    step();
    valid = 0;
    repeat (hold) step();
    dvalid = 1;
    dbits = d;
    dmask = m;
    step();
    dvalid = 0;
  endtask

  initial begin
    reset = 1;
    valid = 0; rw = 0; addr = '0; tag = '0;
    dvalid = 0; dbits = '0; dmask = '0;
    g_valid = 0;
    @(posedge clk);
    #1;
    repeat (2) step();
    reset = 0;
    step();

    for (int i = 0; i < 16; i++)
      do_write(i, rnd128(), 16'hFFFF, i % 3);

    do_write(5, {16{8'hAA}}, 16'hFFFF, 0);
    idle(3);
    do_read(5, 3);
    idle(8);

    for (int t = 0; t < 4; t++)
      do_read(t * 3, t);
    idle(8);

    do_write(7, 128'd0, 16'hFFFF, 0);
    do_write(7, 128'hFF, 16'h0001, 2);
    do_read(7, 11);
    do_read(D + 5, 12);
    idle(8);

    for (int n = 0; n < 400; n++) begin
      valid  = ($urandom % 2) == 1;
      rw     = ($urandom % 3) == 0;
      addr   = 28'(($urandom % 16) + D * ($urandom % 4));
      tag    = 5'($urandom);
      dvalid = ($urandom % 2) == 1;
      dbits  = rnd128();
      dmask  = 16'($urandom);
      step();
    end
    idle(8);

    g_valid = 1;
    idle(14);
    g_valid = 0;
    idle(4);

    do_read(9, 21);
    step();
    reset = 1;
    step();
    reset = 0;
    idle(10);

    valid = 1;
    rw = 1;
    addr = 28'd4;
    step();
    valid = 0;
    dvalid = 1;
    dbits = rnd128();
    dmask = 16'hFFFF;
    reset = 1;
    step();
    reset = 0;
    dvalid = 0;
    do_read(4, 1);
    do_read(9, 2);
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
